// File: rtl/tpu_pkg.sv
// Shared encodings, default widths and width helpers for the tpu tile.
package tpu_pkg;

  localparam int unsigned DEF_N      = 4;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_MATMUL = 2'b10,
    OP_STORE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_STORE   = 2'd3
  } state_e;

  // Accumulator width: full signed product plus headroom for n terms.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned n);
    return 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/tpu_pe.sv
// One systolic MAC element: signed multiply-accumulate with registered
// left->right and top->bottom operand pass-through.
module tpu_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_top,
  output logic [DATA_W-1:0] o_right,
  output logic [DATA_W-1:0] o_down,
  output logic [ACC_W-1:0]  o_acc
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] w_l;
  logic signed [PROD_W-1:0] w_t;
  logic signed [PROD_W-1:0] w_prod;
  logic        [ACC_W-1:0]  w_prod_ext;

  // Full-precision signed product, sign-extended to the accumulator width.
  assign w_l        = PROD_W'($signed(i_left));
  assign w_t        = PROD_W'($signed(i_top));
  assign w_prod     = w_l * w_t;
  assign w_prod_ext = ACC_W'(w_prod);

  // Accumulate and forward operands; clear restarts a fresh multiply.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_acc   <= '0;
      o_right <= '0;
      o_down  <= '0;
    end else if (i_clr) begin
      o_acc   <= '0;
      o_right <= '0;
      o_down  <= '0;
    end else if (i_en) begin
      o_acc   <= o_acc + w_prod_ext;
      o_right <= i_left;
      o_down  <= i_top;
    end
  end

endmodule

// File: rtl/tpu_tile.sv
// Single-tile matrix engine: instruction FSM, operand buffers, skewed feed
// sequencer, N x N systolic PE array and backpressured row store port.
module tpu_tile
  import tpu_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = acc_w(DATA_W, N)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_instr_valid,
  input  logic [1:0]          i_instr_op,
  output logic                o_instr_ready,
  input  logic                i_ld_valid,
  input  logic [N*DATA_W-1:0] i_ld_left,
  input  logic [N*DATA_W-1:0] i_ld_top,
  output logic                o_ld_ready,
  output logic                o_st_valid,
  output logic [N*ACC_W-1:0]  o_st_data,
  output logic                o_st_last,
  input  logic                i_st_ready,
  output logic                o_busy
);

  localparam int unsigned CMP_CYC = 3 * N - 1;
  localparam int unsigned CNT_W   = $clog2(CMP_CYC);

  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD    = 2'(ST_LOAD);
  localparam logic [1:0] S_COMPUTE = 2'(ST_COMPUTE);
  localparam logic [1:0] S_STORE   = 2'(ST_STORE);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clr;
  logic             w_ld_fire;
  logic             w_en;

  logic [DATA_W-1:0] r_a [N][N];
  logic [DATA_W-1:0] r_b [N][N];

  logic [DATA_W-1:0] w_left [N];
  logic [DATA_W-1:0] w_top  [N];
  logic [DATA_W-1:0] w_h    [N][N+1];
  logic [DATA_W-1:0] w_v    [N+1][N];
  logic [ACC_W-1:0]  w_acc  [N][N];
  logic [N*ACC_W-1:0] w_row;
  logic               w_unused_edge;

  // Next-state and shared counter (load beat / feed step / store row).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_ld_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_instr_valid) begin
          case (op_e'(i_instr_op))
            OP_LOAD:   w_state_nxt = S_LOAD;
            OP_MATMUL: begin
              w_state_nxt = S_COMPUTE;
              w_clr       = 1'b1;
            end
            OP_STORE:  w_state_nxt = S_STORE;
            default:   w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (i_ld_valid) begin
          w_ld_fire = 1'b1;
          if (r_cnt == CNT_W'(N - 1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (r_cnt == CNT_W'(CMP_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STORE: begin
        if (i_st_ready) begin
          if (r_cnt == CNT_W'(N - 1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Store row selected by the next counter value so st_data is registered.
  always_comb begin
    w_row = '0;
    for (int r = 0; r < int'(N); r++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (int'(w_cnt_nxt) == r) w_row[j*ACC_W +: ACC_W] = w_acc[r][j];
      end
    end
  end

  // State, counter and registered handshake/status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      o_instr_ready <= 1'b1;
      o_ld_ready    <= 1'b0;
      o_st_valid    <= 1'b0;
      o_st_last     <= 1'b0;
      o_busy        <= 1'b0;
      o_st_data     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      o_instr_ready <= (w_state_nxt == S_IDLE);
      o_ld_ready    <= (w_state_nxt == S_LOAD);
      o_st_valid    <= (w_state_nxt == S_STORE);
      o_st_last     <= (w_state_nxt == S_STORE) && (w_cnt_nxt == CNT_W'(N - 1));
      o_busy        <= (w_state_nxt != S_IDLE);
      o_st_data     <= w_row;
    end
  end

  // Operand buffers: beat i fills row i of A and column i of B.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int k = 0; k < int'(N); k++) begin
          r_a[i][k] <= '0;
          r_b[i][k] <= '0;
        end
      end
    end else if (w_ld_fire) begin
      for (int i = 0; i < int'(N); i++) begin
        if (int'(r_cnt) == i) begin
          for (int k = 0; k < int'(N); k++) begin
            r_a[i][k] <= i_ld_left[k*DATA_W +: DATA_W];
            r_b[k][i] <= i_ld_top[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Skewed feed: edge lane i carries element (step - i), zero outside range.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      w_left[i] = '0;
      w_top[i]  = '0;
      if (r_state == S_COMPUTE) begin
        for (int m = 0; m < int'(N); m++) begin
          if (int'(r_cnt) == i + m) begin
            w_left[i] = r_a[i][m];
            w_top[i]  = r_b[m][i];
          end
        end
      end
    end
  end

  assign w_en = (r_state == S_COMPUTE);

  // PE array wiring.
  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign w_h[gi][0] = w_left[gi];
    assign w_v[0][gi] = w_top[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      tpu_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_left  (w_h[gi][gj]),
        .i_top   (w_v[gi][gj]),
        .o_right (w_h[gi][gj+1]),
        .o_down  (w_v[gi+1][gj]),
        .o_acc   (w_acc[gi][gj])
      );
    end
  end

  // Operands leaving the far edges of the array have no consumer.
  always_comb begin
    w_unused_edge = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      w_unused_edge = w_unused_edge ^ (^w_h[i][N]) ^ (^w_v[N][i]);
    end
  end

endmodule

// File: tb/tb_tpu_tile.sv
// Randomised self-checking bench for tpu_tile against a plain matrix model.
module tb_tpu_tile;
  import tpu_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = acc_w(DW, N);
  localparam int          CMP = 3 * int'(N) - 1;

  logic              clk;
  logic              rst_n;
  logic              instr_valid;
  logic [1:0]        instr_op;
  logic              instr_ready;
  logic              ld_valid;
  logic [N*DW-1:0]   ld_left;
  logic [N*DW-1:0]   ld_top;
  logic              ld_ready;
  logic              st_valid;
  logic [N*AW-1:0]   st_data;
  logic              st_last;
  logic              st_ready;
  logic              busy;

  int checks;
  int errors;

  int ma [N][N];
  int mb [N][N];
  int mc [N][N];

  tpu_tile #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_instr_valid (instr_valid),
    .i_instr_op    (instr_op),
    .o_instr_ready (instr_ready),
    .i_ld_valid    (ld_valid),
    .i_ld_left     (ld_left),
    .i_ld_top      (ld_top),
    .o_ld_ready    (ld_ready),
    .o_st_valid    (st_valid),
    .o_st_data     (st_data),
    .o_st_last     (st_last),
    .i_st_ready    (st_ready),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result: plain matrix product.
  task automatic compute_model();
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        int s;
        s = 0;
        for (int k = 0; k < int'(N); k++) s += ma[i][k] * mb[k][j];
        mc[i][j] = s;
      end
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < int'(N); i++) begin
      for (int k = 0; k < int'(N); k++) begin
        case (mode)
          0: begin ma[i][k] = 0; mb[i][k] = 0; end
          1: begin ma[i][k] = -128; mb[i][k] = -128; end
          default: begin
            ma[i][k] = int'($urandom_range(0, 255)) - 128;
            mb[i][k] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    end
  endtask

  task automatic issue(input logic [1:0] op);
    int guard;
    guard = 0;
    while (!instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("instr_ready_idle", 64'(instr_ready), 64'(1));
    instr_valid = 1'b1;
    instr_op    = op;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op    = 2'b00;
  endtask

  task automatic do_load(input bit hold_mm);
    int i;
    int guard;
    logic [N*DW-1:0] l;
    logic [N*DW-1:0] t;
    bit stall;
    issue(2'b01);
    if (hold_mm) begin
      instr_valid = 1'b1;
      instr_op    = 2'b10;
    end
    i = 0;
    guard = 0;
    while (i < int'(N) && guard < 200) begin
      stall = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < int'(N); k++) begin
        l[k*DW +: DW] = DW'(ma[i][k]);
        t[k*DW +: DW] = DW'(mb[k][i]);
      end
      ld_left  = l;
      ld_top   = t;
      ld_valid = !stall;
      check("ld_ready", 64'(ld_ready), 64'(1));
      if (hold_mm) check("instr_ready_blocked", 64'(instr_ready), 64'(0));
      @(negedge clk);
      if (!stall) i++;
      guard++;
    end
    ld_valid    = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 2'b00;
    check("load_beats", 64'(i), 64'(N));
    check("load_done_busy", 64'(busy), 64'(0));
  endtask

  task automatic do_matmul();
    int cnt;
    issue(2'b10);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("compute_cycles", 64'(cnt), 64'(CMP));
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random
  task automatic do_store(input int mode);
    int r;
    int cyc;
    bit rdy;
    logic [AW-1:0] e;
    issue(2'b11);
    check("st_valid_rise", 64'(st_valid), 64'(1));
    r = 0;
    cyc = 0;
    while (r < int'(N) && cyc < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      st_ready = rdy;
      check("st_valid", 64'(st_valid), 64'(1));
      check("st_last", 64'(st_last), 64'(r == int'(N) - 1));
      for (int j = 0; j < int'(N); j++) begin
        e = AW'(mc[r][j]);
        check($sformatf("st_data r%0d c%0d", r, j), 64'(st_data[j*AW +: AW]), 64'(e));
      end
      @(negedge clk);
      if (rdy) r++;
      cyc++;
    end
    st_ready = 1'b0;
    check("store_rows", 64'(r), 64'(N));
    check("store_end_valid", 64'(st_valid), 64'(0));
    check("store_end_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr_op = 2'b00;
    ld_valid = 1'b0;
    ld_left = '0;
    ld_top = '0;
    st_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_st_valid", 64'(st_valid), 64'(0));
    check("rst_ld_ready", 64'(ld_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_instr_ready", 64'(instr_ready), 64'(1));

    // NOP keeps the tile idle
    issue(2'b00);
    check("nop_busy", 64'(busy), 64'(0));

    // STORE before any MATMUL, then MATMUL on reset buffers
    fill(0);
    compute_model();
    do_store(0);
    do_matmul();
    do_store(0);

    // basic 2x2 product in the top-left corner
    fill(0);
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    compute_model();
    do_load(0);
    do_matmul();
    do_store(0);

    // signed: -I times the same B
    ma[0][0] = -1; ma[0][1] = 0; ma[1][0] = 0; ma[1][1] = -1;
    compute_model();
    do_load(0);
    do_matmul();
    do_store(0);

    // extreme negative operands
    fill(1);
    compute_model();
    do_load(0);
    do_matmul();
    do_store(0);

    // backpressure pattern
    fill(2);
    compute_model();
    do_load(0);
    do_matmul();
    do_store(1);

    // MATMUL held during LOAD is ignored; repeated STORE
    fill(2);
    compute_model();
    do_load(1);
    do_matmul();
    do_store(0);
    do_store(1);

    // reset during COMPUTE
    issue(2'b10);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_st_valid", 64'(st_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_instr_ready", 64'(instr_ready), 64'(1));
    fill(0);
    compute_model();
    do_store(0);
    fill(2);
    compute_model();
    do_load(0);
    do_matmul();
    do_store(0);

    // randomised runs
    for (int n = 0; n < 100; n++) begin
      fill(2);
      compute_model();
      do_load(0);
      do_matmul();
      do_store(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_tile.md
# tpu_tile

Parametrised single-tile matrix engine. Accepts N×N operand matrices over a row-beat load port, runs a skewed systolic multiply on an internal N×N PE array, and streams the N×N result out row by row. It is the successor to the fixed-size TPU top: it generalises array size and widths, and it adds the following:
- an instruction handshake;
- internal operand buffering;
- a skew/feed sequencer;
- a backpressured result port.

## Interface
- N, 4: array dimension; matrices are N×N; N ≥ 2
- DATA_W, 8: operand width, signed two's complement
- ACC_W, 2*DATA_W+$clog2(N): accumulator/result width, signed
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_op  in  2  00 NOP, 01 LOAD, 10 MATMUL, 11 STORE
- instr_ready  out  1  instruction accepted when high with instr_valid
- ld_valid  in  1  load beat offered
- ld_left  in  N*DATA_W  row i of A; element k at bits [k*DATA_W +: DATA_W]
- ld_top  in  N*DATA_W  column i of B; same packing
- ld_ready  out  1  load beat accepted
- st_valid  out  1  result row valid
- st_data  out  N*ACC_W  row r of C; element j at bits [j*ACC_W +: ACC_W]
- st_last  out  1  high with the final row (r = N-1)
- st_ready  in  1  result consumer ready
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, COMPUTE, STORE.
- IDLE: instr_ready=1. An accepted op chooses the next state:
  - NOP: stay IDLE.
  - LOAD: go to LOAD.
  - MATMUL: go to COMPUTE.
  - STORE: go to STORE.
- LOAD: ld_ready=1.
  - Beat i (i = 0..N-1, counted on ld_valid&&ld_ready) writes A[i][*] := ld_left and B[*][i] := ld_top.
  - After beat N-1, return to IDLE.
  - Buffers keep their contents until the next LOAD or reset.
- COMPUTE: on entry, clear all accumulators and the feed counter k.
  - For k = 0..2N-2, left edge row i is driven with A[i][k-i] when 0 ≤ k-i < N, else 0.
  - For the same k, top edge column j is driven with B[k-j][j] under the same rule.
  - PE(i,j) computes acc += left_in*top_in (signed, full product, sign-extended to ACC_W, wraps modulo 2^ACC_W).
  - PE(i,j) registers left_in to its right neighbour and top_in to its lower neighbour.
  - On completion, PE(i,j) holds C[i][j] = Σk A[i][k]·B[k][j].
- STORE: present row r (r = 0..N-1) of C on st_data with st_valid=1.
  - Advance r on st_valid&&st_ready.
  - st_last=1 when r=N-1.
  - After that row's handshake, return to IDLE.
  - Accumulators are not cleared by STORE, so repeated STOREs return the same C.
- STORE before any MATMUL returns all zeros.
- MATMUL without a prior LOAD uses the buffer contents, which are zero after reset.
- Reset (asserted at any time, including mid-COMPUTE or mid-STORE) clears:
  - the state to IDLE;
  - all counters, operand buffers and accumulators;
  - st_valid, st_last and ld_ready to 0 and busy to 0.
  - instr_ready reads 1 once reset is released.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Instruction accept → first cycle of the new state: 1 clock.
- LOAD occupies N accepted beats. ld_valid stalls are allowed, and the beat counter holds while ld_valid=0.
- COMPUTE lasts exactly 3N-1 cycles: 2N-1 feed cycles plus N propagation/settle cycles. busy drops in the following cycle. For N=4 this is 11 cycles.
- STORE: st_valid rises 1 cycle after the accept.
  - While st_valid && !st_ready, st_data and st_last are held stable.
  - With st_ready held high, N rows take N consecutive cycles.
- Result registers update only in COMPUTE, so st_data never changes mid-handshake.
- instr_valid is ignored while busy=1; no instruction is queued.

## Structure
- Package tpu_pkg holds:
  - the op_e encoding (NOP/LOAD/MATMUL/STORE);
  - the state_e enum;
  - default DATA_W and the ACC_W helper function.
- Sub-module tpu_pe: one MAC processing element containing
  - signed multiply and accumulator;
  - registered left→right and top→bottom pass-through;
  - a synchronous clear input driven on COMPUTE entry.
- The array is built from tpu_pe with a generate loop.
- The feed sequencer, operand buffers, FSM and store mux live in tpu_tile.

## Test plan
- Basic multiply, N=2, DATA_W=8: LOAD A=[[1,2],[3,4]], B=[[5,6],[7,8]]; MATMUL; STORE with st_ready=1.
  - Expected: rows {19,22}, then {43,50}; st_last on row 1.
  - busy is high for exactly 5 COMPUTE cycles.
- Signed multiply, N=2: A=[[-1,0],[0,-1]] × the same B gives {-5,-6}, {-7,-8}.
  - A all -128 × B all -128 gives every element 32768 with ACC_W=17.
- Backpressure: st_ready toggles 1,0,0,1 during STORE.
  - st_data stays stable while stalled.
  - Exactly N row handshakes occur, with no duplicates or drops.
- Busy blocking and repeated STORE:
  - instr_valid with MATMUL held during a LOAD → ld_ready stays high and instr_ready stays 0 until the load completes.
  - A second STORE returns an identical C.
- Reset mid-COMPUTE at cycle 3: busy=0, st_valid=0.
  - A following STORE returns all zeros.
  - LOAD followed by MATMUL then produces the correct C.
- Default-parameter randomised check, N=4, DATA_W=8: 100 random signed A and B, each compared against a reference model.
  - COMPUTE lasts 11 cycles in every run.
